// File: rtl/axis_bram_recorder.sv
// Triggered AXI-Stream to BRAM port-A recorder. Beats are written to a circular buffer with zero latency.
// Upstream is never stalled: tready stays 1 out of reset, and beats arriving while idle or done are dropped.
module axis_bram_recorder #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [2*BRAM_ADDR_WIDTH:0]    cfg_data,
  input  logic                          arm,
  input  logic                          trg_flag,
  output logic [2*BRAM_ADDR_WIDTH:0]    sts_data,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          bram_porta_clk,
  output logic                          bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_porta_addr,
  output logic [AXIS_TDATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic                          bram_porta_we
);

  localparam int A = BRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    CONT  = 3'd5
  } state_t;

  state_t         state;
  logic [A-1:0]   addr;
  logic [A-1:0]   trig_addr;
  logic [A-1:0]   cnt;
  logic [A-1:0]   pre_r;
  logic [A-1:0]   post_r;
  logic           mode_r;
  logic           done;
  logic           tready;

  logic           accept;
  logic           write;
  logic           arm_ok;
  logic [A-1:0]   cnt_inc;

  assign accept  = s_axis_tvalid & tready;
  assign write   = accept & (state inside {PRE, ARMED, POST, CONT});
  assign arm_ok  = arm & (state inside {IDLE, DONE, CONT});
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      addr      <= '0;
      trig_addr <= '0;
      cnt       <= '0;
      pre_r     <= '0;
      post_r    <= '0;
      mode_r    <= 1'b0;
      done      <= 1'b0;
      tready    <= 1'b0;
    end else begin
      tready <= 1'b1;
      if (arm_ok) begin
        // A beat coinciding with the arm in CONT is still written at the old addr; the new run starts at 0.
        pre_r  <= cfg_data[A-1:0];
        post_r <= cfg_data[2*A-1:A];
        mode_r <= cfg_data[2*A];
        addr   <= '0;
        cnt    <= '0;
        done   <= 1'b0;
        if (cfg_data[2*A])
          state <= CONT;
        else if (cfg_data[A-1:0] == '0)
          state <= ARMED;
        else
          state <= PRE;
      end else begin
        unique case (state)
          PRE: begin
            if (write) begin
              addr <= addr + 1'b1;
              cnt  <= cnt_inc;
              if (cnt_inc == pre_r)
                state <= ARMED;
            end
          end
          ARMED: begin
            if (write) begin
              addr <= addr + 1'b1;
              if (trg_flag) begin
                trig_addr <= addr;
                cnt       <= '0;
                if (post_r == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= POST;
                end
              end
            end
          end
          POST: begin
            if (write) begin
              addr <= addr + 1'b1;
              cnt  <= cnt_inc;
              if (cnt_inc == post_r) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          CONT: begin
            if (write)
              addr <= addr + 1'b1;
          end
          IDLE, DONE: begin
            addr <= addr;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign s_axis_tready     = tready;
  assign sts_data          = {done, trig_addr, addr};
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = areset;
  assign bram_porta_addr   = addr;
  assign bram_porta_wrdata = s_axis_tdata;
  assign bram_porta_we     = write;

endmodule

// File: tb/tb_axis_bram_recorder.sv
// Directed bench for axis_bram_recorder with a 16-word buffer and incrementing-counter data.
module tb_axis_bram_recorder;

  localparam int W = 16;
  localparam int A = 4;

  logic             aclk;
  logic             areset;
  logic [2*A:0]     cfg_data;
  logic             arm;
  logic             trg_flag;
  logic [2*A:0]     sts_data;
  logic             s_axis_tready;
  logic [W-1:0]     s_axis_tdata;
  logic             s_axis_tvalid;
  logic             bram_porta_clk;
  logic             bram_porta_rst;
  logic [A-1:0]     bram_porta_addr;
  logic [W-1:0]     bram_porta_wrdata;
  logic             bram_porta_we;

  int               n_total;
  int               n_pass;
  int               n_fail;
  logic [W-1:0]     dcnt;

  axis_bram_recorder #(
    .AXIS_TDATA_WIDTH(W),
    .BRAM_ADDR_WIDTH (A)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .cfg_data         (cfg_data),
    .arm              (arm),
    .trg_flag         (trg_flag),
    .sts_data         (sts_data),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .bram_porta_clk   (bram_porta_clk),
    .bram_porta_rst   (bram_porta_rst),
    .bram_porta_addr  (bram_porta_addr),
    .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we    (bram_porta_we)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [2*A:0] mk_cfg(input logic mode, input logic [A-1:0] post, input logic [A-1:0] pre);
    return {mode, post, pre};
  endfunction

  function automatic logic [2*A:0] mk_sts(input logic dn, input logic [A-1:0] ta, input logic [A-1:0] wa);
    return {dn, ta, wa};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One beat: drive, check the combinational write strobe/address, then clock it in.
  task automatic beat(input string tag, input logic trg, input logic exp_we, input logic [A-1:0] exp_addr);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = dcnt;
    trg_flag      = trg;
    #1;
    check({tag, "_we"}, 32'(bram_porta_we), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_addr"}, 32'(bram_porta_addr), 32'(exp_addr));
      check({tag, "_wrdata"}, 32'(bram_porta_wrdata), 32'(dcnt));
    end
    @(posedge aclk);
    #1;
    dcnt     = dcnt + 1'b1;
    trg_flag = 1'b0;
  endtask

  task automatic do_arm(input logic [2*A:0] cfg);
    cfg_data      = cfg;
    arm           = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int written;
    logic v;
    n_total = 0; n_pass = 0; n_fail = 0;
    dcnt = '0;
    areset = 1'b1; arm = 1'b0; trg_flag = 1'b0;
    cfg_data = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;

    // 1: reset and idle
    tick(); tick(); tick();
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_sts", 32'(sts_data), 32'd0);
    areset = 1'b0;
    #1;
    check("rst_tready_low_still", 32'(s_axis_tready), 32'd0);
    tick();
    check("rst_tready_up", 32'(s_axis_tready), 32'd1);
    for (int i = 0; i < 10; i++) beat($sformatf("idle%0d", i), 1'b0, 1'b0, '0);
    s_axis_tvalid = 1'b0;
    check("idle_sts", 32'(sts_data), 32'd0);

    // 2: pre=3 post=4, trigger on beat 9
    do_arm(mk_cfg(1'b0, 4'd4, 4'd3));
    check("t2_arm_sts", 32'(sts_data), 32'(mk_sts(1'b0, 4'd0, 4'd0)));
    for (int i = 0; i < 16; i++) begin
      beat($sformatf("t2_b%0d", i), i == 9, i <= 13, A'(i));
      check($sformatf("t2_done%0d", i), 32'(sts_data[2*A]), 32'(i >= 13));
    end
    s_axis_tvalid = 1'b0;
    check("t2_sts", 32'(sts_data), 32'(mk_sts(1'b1, 4'd9, 4'd14)));

    // 3: trigger during PRE ignored, real trigger on beat 5
    do_arm(mk_cfg(1'b0, 4'd4, 4'd3));
    check("t3_arm_sts", 32'(sts_data), 32'(mk_sts(1'b0, 4'd9, 4'd0)));
    for (int i = 0; i < 12; i++) beat($sformatf("t3_b%0d", i), (i == 1) || (i == 5), i <= 9, A'(i));
    s_axis_tvalid = 1'b0;
    check("t3_sts", 32'(sts_data), 32'(mk_sts(1'b1, 4'd5, 4'd10)));

    // 4: pre=2 post=0, trigger on beat 20 after wrapping
    do_arm(mk_cfg(1'b0, 4'd0, 4'd2));
    for (int i = 0; i < 22; i++) begin
      beat($sformatf("t4_b%0d", i), i == 20, i <= 20, A'(i % 16));
      if (i == 19) check("t4_not_done", 32'(sts_data[2*A]), 32'd0);
    end
    s_axis_tvalid = 1'b0;
    check("t4_sts", 32'(sts_data), 32'(mk_sts(1'b1, 4'd4, 4'd5)));

    // 5: continuous mode with random tvalid gaps
    do_arm(mk_cfg(1'b1, 4'd0, 4'd0));
    written = 0;
    for (int k = 0; k < 400; k++) begin
      if (written == 40) break;
      v = ($urandom_range(0, 3) != 0);
      s_axis_tvalid = v;
      s_axis_tdata  = dcnt;
      trg_flag      = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("t5_we%0d", k), 32'(bram_porta_we), 32'(v));
      if (v) begin
        check($sformatf("t5_addr%0d", k), 32'(bram_porta_addr), 32'(written % 16));
        written++;
        dcnt = dcnt + 1'b1;
      end
      tick();
    end
    s_axis_tvalid = 1'b0; trg_flag = 1'b0;
    check("t5_count", 32'(written), 32'd40);
    check("t5_sts", 32'(sts_data), 32'(mk_sts(1'b0, 4'd4, 4'd8)));

    // arm together with a beat in CONT: beat written at old addr, new run starts at 0
    cfg_data = mk_cfg(1'b0, 4'd4, 4'd3);
    arm = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = dcnt;
    #1;
    check("t5_armbeat_we", 32'(bram_porta_we), 32'd1);
    check("t5_armbeat_addr", 32'(bram_porta_addr), 32'd8);
    tick();
    arm = 1'b0; s_axis_tvalid = 1'b0; dcnt = dcnt + 1'b1;
    check("t5_rearm_sts", 32'(sts_data), 32'(mk_sts(1'b0, 4'd4, 4'd0)));

    // 6: PRE run, arm ignored in ARMED, reset mid-POST
    beat("t6_b0", 1'b0, 1'b1, 4'd0);
    beat("t6_b1", 1'b0, 1'b1, 4'd1);
    beat("t6_b2", 1'b0, 1'b1, 4'd2);
    cfg_data = mk_cfg(1'b1, 4'd0, 4'd0);
    arm = 1'b1;
    beat("t6_b3", 1'b0, 1'b1, 4'd3);
    arm = 1'b0;
    beat("t6_b4", 1'b1, 1'b1, 4'd4);
    beat("t6_b5", 1'b0, 1'b1, 4'd5);
    s_axis_tvalid = 1'b0;
    check("t6_post_sts", 32'(sts_data), 32'(mk_sts(1'b0, 4'd4, 4'd6)));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("t6_rst_sts", 32'(sts_data), 32'd0);
    check("t6_rst_tready", 32'(s_axis_tready), 32'd0);
    s_axis_tvalid = 1'b1;
    #1;
    check("t6_rst_we", 32'(bram_porta_we), 32'd0);
    tick();
    s_axis_tvalid = 1'b0;
    check("t6_tready_back", 32'(s_axis_tready), 32'd1);
    check("t6_idle_sts", 32'(sts_data), 32'd0);
    do_arm(mk_cfg(1'b0, 4'd1, 4'd0));
    beat("t6_r0", 1'b0, 1'b1, 4'd0);
    beat("t6_r1", 1'b1, 1'b1, 4'd1);
    beat("t6_r2", 1'b0, 1'b1, 4'd2);
    beat("t6_r3", 1'b0, 1'b0, 4'd3);
    s_axis_tvalid = 1'b0;
    check("t6_final_sts", 32'(sts_data), 32'(mk_sts(1'b1, 4'd1, 4'd3)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
